// File: rtl/gain_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gain_ramp_ctrl
// Description : Ramps the applied gain word toward the effective target
//               (latched target, or zero while muted) by a fixed step per
//               audio sample strobe, so gain changes and mute never click.
// Revision    : 1.0 - initial release
// ============================================================================
module gain_ramp_ctrl #(
    parameter int GAIN_W         = 16,
    parameter int BITS_PER_LEVEL = 12,
    parameter int RAMP_STEP      = 16,
    parameter int RESET_GAIN     = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sample_valid,
    input  logic [GAIN_W-1:0] i_target_gain,
    input  logic              i_target_load,
    input  logic              i_mute,
    output logic [GAIN_W-1:0] o_gain,
    output logic              o_ramping,
    output logic              o_settled
);

    localparam logic [0:0]        c_IDLE       = 1'b0;
    localparam logic [0:0]        c_RAMP       = 1'b1;
    localparam logic [GAIN_W:0]   c_STEP_WIDE  = (GAIN_W+1)'(RAMP_STEP);
    localparam logic [GAIN_W-1:0] c_STEP       = c_STEP_WIDE[GAIN_W-1:0];
    localparam logic [GAIN_W-1:0] c_RESET_GAIN = GAIN_W'(RESET_GAIN);

    // Reject configurations the gain stage or the stepper cannot support.
    if (RAMP_STEP < 1) begin : g_bad_step
        $error("gain_ramp_ctrl: RAMP_STEP must be at least 1");
    end
    if (BITS_PER_LEVEL >= GAIN_W) begin : g_bad_fraction
        $error("gain_ramp_ctrl: unity gain does not fit in GAIN_W bits");
    end

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [GAIN_W-1:0] r_target;
    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] w_gain_nxt;
    logic              r_settled;
    logic              w_settle_nxt;
    logic [GAIN_W-1:0] w_eff;
    logic [GAIN_W:0]   w_sum;
    logic [GAIN_W-1:0] w_up;
    logic              w_borrow;
    logic [GAIN_W-1:0] w_diff;
    logic [GAIN_W-1:0] w_dn;

    // Effective target and the clamped up/down step candidates.
    always_comb begin
        w_eff    = i_mute ? '0 : r_target;
        // One extra bit so a target near full scale cannot wrap the sum.
        w_sum    = {1'b0, r_gain} + c_STEP_WIDE;
        w_up     = (w_sum > {1'b0, w_eff}) ? w_eff : w_sum[GAIN_W-1:0];
        // Borrow means the step would go below zero, so clamp to target.
        w_borrow = ({1'b0, r_gain} < c_STEP_WIDE);
        w_diff   = r_gain - c_STEP;
        w_dn     = (w_borrow || (w_diff < w_eff)) ? w_eff : w_diff;
    end

    // Next-state, next-gain and settle-pulse decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_gain_nxt   = r_gain;
        w_settle_nxt = 1'b0;
        if (r_state == c_IDLE) begin
            if (r_gain != w_eff) begin
                w_state_nxt = c_RAMP;
            end
        end else begin
            if (r_gain == w_eff) begin
                w_state_nxt  = c_IDLE;
                w_settle_nxt = 1'b1;
            end else if (i_sample_valid) begin
                w_gain_nxt = (r_gain < w_eff) ? w_up : w_dn;
            end
        end
    end

    // State, gain, target and settle-pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_IDLE;
            r_gain    <= c_RESET_GAIN;
            r_target  <= c_RESET_GAIN;
            r_settled <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gain    <= w_gain_nxt;
            r_settled <= w_settle_nxt;
            if (i_target_load) begin
                r_target <= i_target_gain;
            end
        end
    end

    assign o_gain    = r_gain;
    assign o_ramping = (r_state == c_RAMP);
    assign o_settled = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_gain_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gain_ramp_ctrl
// Description : Directed self-checking bench for gain_ramp_ctrl
//               (GAIN_W=16, RAMP_STEP=16, RESET_GAIN=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gain_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] target_gain;
    logic        target_load;
    logic        mute;
    logic [15:0] gain;
    logic        ramping;
    logic        settled;

    int checks;
    int failures;
    int settle_cnt;
    int settle_base;

    gain_ramp_ctrl #(
        .GAIN_W         (16),
        .BITS_PER_LEVEL (12),
        .RAMP_STEP      (16),
        .RESET_GAIN     (0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample_valid (sample_valid),
        .i_target_gain  (target_gain),
        .i_target_load  (target_load),
        .i_mute         (mute),
        .o_gain         (gain),
        .o_ramping      (ramping),
        .o_settled      (settled)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count settle pulses away from the active edge.
    always @(negedge clk) begin
        if (settled === 1'b1) settle_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and samples both move 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Pulse load for one edge, then one more edge for IDLE->RAMP.
    task automatic do_load(input logic [15:0] v);
        target_gain = v;
        target_load = 1'b1;
        tick();
        target_load = 1'b0;
        tick();
    endtask

    // n strobes, one every 4 cycles.
    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            tick();
            tick();
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
        end
    endtask

    // Hold the strobe high until a settle pulse appears or the budget runs out.
    task automatic ramp_to(input string tag, input logic [15:0] exp, input int budget);
        int n;
        n = 0;
        sample_valid = 1'b1;
        while (settled !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        sample_valid = 1'b0;
        chk({tag, "_settle_seen"}, {31'd0, settled}, 32'd1);
        chk({tag, "_gain"}, {16'd0, gain}, {16'd0, exp});
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        settle_cnt   = 0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        target_gain  = '0;
        target_load  = 1'b0;
        mute         = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_gain", {16'd0, gain}, 32'd0);
        chk("reset_ramping", {31'd0, ramping}, 32'd0);
        chk("reset_settled", {31'd0, settled}, 32'd0);

        // Load 64: ramp 16,32,48,64 then a single settle pulse.
        target_gain = 16'd64;
        target_load = 1'b1;
        tick();
        target_load = 1'b0;
        chk("load_edge_not_ramping", {31'd0, ramping}, 32'd0);
        tick();
        chk("load_next_edge_ramping", {31'd0, ramping}, 32'd1);
        chk("load_no_step_yet", {16'd0, gain}, 32'd0);
        settle_base = settle_cnt;
        for (int k = 1; k <= 4; k++) begin
            strobes(1);
            chk("ramp64_step", {16'd0, gain}, 32'(16 * k));
        end
        chk("ramp64_not_settled_at_final_step", {31'd0, settled}, 32'd0);
        tick();
        chk("ramp64_settled", {31'd0, settled}, 32'd1);
        chk("ramp64_ramping_low", {31'd0, ramping}, 32'd0);
        tick();
        chk("ramp64_settle_one_cycle", {31'd0, settled}, 32'd0);
        chk("ramp64_settle_count", 32'(settle_cnt - settle_base), 32'd1);

        // Strobes in IDLE are ignored; same-value load makes no transition.
        strobes(2);
        chk("idle_strobe_ignored", {16'd0, gain}, 32'd64);
        settle_base = settle_cnt;
        do_load(16'd64);
        chk("same_load_no_ramp", {31'd0, ramping}, 32'd0);
        strobes(1);
        chk("same_load_no_settle", 32'(settle_cnt - settle_base), 32'd0);

        // Load 70 from 0: final step clamps to 70.
        do_reset();
        do_load(16'd70);
        strobes(4);
        chk("ramp70_step4", {16'd0, gain}, 32'd64);
        strobes(1);
        chk("ramp70_clamp", {16'd0, gain}, 32'd70);
        tick();
        chk("ramp70_settled", {31'd0, settled}, 32'd1);

        // Near full scale: no wrap on the way up, no underflow on the way down.
        do_reset();
        do_load(16'hFFF8);
        ramp_to("ramp_fff8", 16'hFFF8, 5000);
        tick();
        do_load(16'hFFFF);
        strobes(1);
        chk("no_wrap_ffff", {16'd0, gain}, 32'h0000FFFF);
        tick();
        do_load(16'h0010);
        ramp_to("ramp_down_0010", 16'h0010, 5000);
        tick();
        do_load(16'h0005);
        strobes(1);
        chk("no_underflow_0005", {16'd0, gain}, 32'h00000005);

        // Mute ramps 4096 -> 0 in 256 strobes and back, target retained.
        do_reset();
        do_load(16'd4096);
        ramp_to("ramp_4096", 16'd4096, 1000);
        tick();
        mute = 1'b1;
        tick();
        chk("mute_starts_ramp", {31'd0, ramping}, 32'd1);
        strobes(255);
        chk("mute_step255", {16'd0, gain}, 32'd16);
        strobes(1);
        chk("mute_at_zero", {16'd0, gain}, 32'd0);
        tick();
        chk("mute_settled", {31'd0, settled}, 32'd1);
        mute = 1'b0;
        tick();
        strobes(256);
        chk("unmute_back_4096", {16'd0, gain}, 32'd4096);

        // Redirect mid-ramp: load 512 together with a strobe at gain 1024.
        do_reset();
        do_load(16'd4096);
        strobes(64);
        chk("redir_at_1024", {16'd0, gain}, 32'd1024);
        settle_base = settle_cnt;
        tick();
        target_gain  = 16'd512;
        target_load  = 1'b1;
        sample_valid = 1'b1;
        tick();
        target_load  = 1'b0;
        sample_valid = 1'b0;
        chk("redir_old_eff_step", {16'd0, gain}, 32'd1040);
        strobes(1);
        chk("redir_first_down", {16'd0, gain}, 32'd1024);
        strobes(1);
        chk("redir_second_down", {16'd0, gain}, 32'd1008);
        strobes(31);
        chk("redir_reach_512", {16'd0, gain}, 32'd512);
        tick();
        tick();
        chk("redir_single_settle", 32'(settle_cnt - settle_base), 32'd1);

        // Reset mid-ramp at 800: abandon ramp silently.
        do_reset();
        do_load(16'd4096);
        strobes(50);
        chk("rst_mid_at_800", {16'd0, gain}, 32'd800);
        settle_base = settle_cnt;
        do_reset();
        chk("rst_mid_gain", {16'd0, gain}, 32'd0);
        chk("rst_mid_ramping", {31'd0, ramping}, 32'd0);
        strobes(3);
        chk("rst_mid_strobes_hold", {16'd0, gain}, 32'd0);
        chk("rst_mid_no_settle", 32'(settle_cnt - settle_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
